mem_port_arbiter: RTL and testbench

- Shares the single physical memory port between two requesters: m0 is the MMU's downstream request port and m1 is the boot loader / debug master.
- Each requester uses a pulse request/response protocol with at most one outstanding transaction.
- Pulses are captured into a 1-entry buffer per requester and granted round-robin, one transaction at a time.
- Responses are routed back to the granted requester.

---
 rtl/mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one physical memory port between two requesters:
//   m0 : MMU downstream request port
//   m1 : boot loader / debug master
// Each requester pulses a request (at most one outstanding). The pulse is
// granted straight away when the port is idle, or parked in a 1-entry buffer
// for that requester. Grants are round-robin, one transaction at a time. The
// memory response is returned to the granted requester one cycle later.
//
// Handshake semantics (all pulse based, no back-pressure):
//   mN_request_enable  : one-cycle pulse; fields mN_req_* sampled in that cycle.
//   request_enable     : one-cycle pulse to memory; req_* held through WAIT.
//   response_enable    : one-cycle pulse from memory; only honoured in WAIT.
//   mN_response_enable : one-cycle pulse; mN_resp_data held until next response.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mN_request_enable/req_*       requester N request (N = 0, 1)
//   mN_response_enable/resp_data  requester N response
//   request_enable/req_*          granted request towards memory
//   response_enable/resp_data     memory response
//   busy                          high while a transaction is outstanding (WAIT)
//   protocol_err                  sticky: request pulse while previous one unfinished
//   timeout_err                   sticky watchdog flag
//   dbg_state                     FSM state (0 = IDLE, 1 = WAIT)
//
// Build option: define ARB_TIMEOUT_EN to enable the WAIT watchdog. Without
// it WAIT lasts until response_enable and timeout_err is tied to 0.

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_request_enable,
  input  logic        m0_req_mode,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  output logic        m0_response_enable,
  output logic [31:0] m0_resp_data,
  input  logic        m1_request_enable,
  input  logic        m1_req_mode,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  output logic        m1_response_enable,
  output logic [31:0] m1_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy,
  output logic        protocol_err,
  output logic        timeout_err,
  output logic        dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Requester inputs gathered into arrays indexed by requester id.
  logic [1:0]  w_in_en;
  logic        w_in_mode  [2];
  logic [31:0] w_in_addr  [2];
  logic [31:0] w_in_wdata [2];
  logic [3:0]  w_in_wstrb [2];

  assign w_in_en       = {m1_request_enable, m0_request_enable};
  assign w_in_mode[0]  = m0_req_mode;
  assign w_in_mode[1]  = m1_req_mode;
  assign w_in_addr[0]  = m0_req_addr;
  assign w_in_addr[1]  = m1_req_addr;
  assign w_in_wdata[0] = m0_req_wdata;
  assign w_in_wdata[1] = m1_req_wdata;
  assign w_in_wstrb[0] = m0_req_wstrb;
  assign w_in_wstrb[1] = m1_req_wstrb;

  logic [0:0]  r_state;
  logic        r_gnt_id;
  logic        r_rr_last;
  logic        r_req_en;
  logic        r_req_mode;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_wstrb;
  logic [1:0]  r_m_resp_en;
  logic [31:0] r_m_resp_data [2];
  logic        r_protocol_err;

  logic [1:0]  r_buf_vld;
  logic        r_buf_mode  [2];
  logic [31:0] r_buf_addr  [2];
  logic [31:0] r_buf_wdata [2];
  logic [3:0]  r_buf_wstrb [2];

  logic        w_idle;
  logic [1:0]  w_cand;
  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic        w_sel_mode;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;
  logic [1:0]  w_inflight;
  logic [1:0]  w_err;
  logic [1:0]  w_cap;
  logic [1:0]  w_clr;
  logic        w_timeout_fire;

  assign w_idle = (r_state == ST_IDLE);

  always_comb begin
    // A buffered request or a fresh pulse (bypass) both compete in IDLE,
    // so a pulse into an idle port costs no extra cycle.
    w_cand      = r_buf_vld | w_in_en;
    w_gnt_valid = w_idle && (w_cand != 2'b00);
    // On a tie the requester that did not win last time goes first.
    w_gnt_id    = (w_cand == 2'b11) ? ~r_rr_last : w_cand[1];
    w_sel_mode  = r_buf_vld[w_gnt_id] ? r_buf_mode[w_gnt_id]  : w_in_mode[w_gnt_id];
    w_sel_addr  = r_buf_vld[w_gnt_id] ? r_buf_addr[w_gnt_id]  : w_in_addr[w_gnt_id];
    w_sel_wdata = r_buf_vld[w_gnt_id] ? r_buf_wdata[w_gnt_id] : w_in_wdata[w_gnt_id];
    w_sel_wstrb = r_buf_vld[w_gnt_id] ? r_buf_wstrb[w_gnt_id] : w_in_wstrb[w_gnt_id];
    w_inflight  = 2'b00;
    w_err       = 2'b00;
    w_cap       = 2'b00;
    w_clr       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_inflight[i] = !w_idle && (r_gnt_id == 1'(i));
      // Pulse while the requester already has something pending is dropped.
      w_err[i]      = w_in_en[i] && (r_buf_vld[i] || w_inflight[i]);
      w_clr[i]      = w_gnt_valid && (w_gnt_id == 1'(i));
      // A bypassed pulse that wins the grant this cycle is not buffered.
      w_cap[i]      = w_in_en[i] && !r_buf_vld[i] && !w_inflight[i] && !w_clr[i];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  // A real response in the expiry cycle takes precedence over the watchdog.
  assign w_timeout_fire = !w_idle && !response_enable &&
                          (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Held at zero in IDLE, so it starts at zero on every WAIT entry.
      if (w_idle) r_wait_cnt <= '0;
      else        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout_fire) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg   = ^32'(TIMEOUT_CYCLES);
  assign w_timeout_fire = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_gnt_id       <= 1'b0;
      r_rr_last      <= 1'b1;
      r_req_en       <= 1'b0;
      r_req_mode     <= 1'b0;
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_wstrb    <= '0;
      r_m_resp_en    <= '0;
      r_protocol_err <= 1'b0;
      r_buf_vld      <= '0;
      for (int i = 0; i < 2; i++) begin
        r_m_resp_data[i] <= '0;
        r_buf_mode[i]    <= 1'b0;
        r_buf_addr[i]    <= '0;
        r_buf_wdata[i]   <= '0;
        r_buf_wstrb[i]   <= '0;
      end
    end else begin
      r_req_en    <= 1'b0;
      r_m_resp_en <= '0;
      if (w_err != 2'b00) r_protocol_err <= 1'b1;

      for (int i = 0; i < 2; i++) begin
        if (w_clr[i]) begin
          r_buf_vld[i] <= 1'b0;
        end else if (w_cap[i]) begin
          r_buf_vld[i]   <= 1'b1;
          r_buf_mode[i]  <= w_in_mode[i];
          r_buf_addr[i]  <= w_in_addr[i];
          r_buf_wdata[i] <= w_in_wdata[i];
          r_buf_wstrb[i] <= w_in_wstrb[i];
        end
      end

      case (r_state)
        ST_IDLE: begin
          // response_enable here is stray and deliberately ignored.
          if (w_gnt_valid) begin
            r_state     <= ST_WAIT;
            r_req_en    <= 1'b1;
            r_req_mode  <= w_sel_mode;
            r_req_addr  <= w_sel_addr;
            r_req_wdata <= w_sel_wdata;
            r_req_wstrb <= w_sel_wstrb;
            r_gnt_id    <= w_gnt_id;
            r_rr_last   <= w_gnt_id;
          end
        end
        ST_WAIT: begin
          if (response_enable || w_timeout_fire) begin
            r_state                 <= ST_IDLE;
            r_m_resp_en[r_gnt_id]   <= 1'b1;
            r_m_resp_data[r_gnt_id] <= response_enable ? resp_data : ERR_DATA;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign request_enable     = r_req_en;
  assign req_mode           = r_req_mode;
  assign req_addr           = r_req_addr;
  assign req_wdata          = r_req_wdata;
  assign req_wstrb          = r_req_wstrb;
  assign m0_response_enable = r_m_resp_en[0];
  assign m1_response_enable = r_m_resp_en[1];
  assign m0_resp_data       = r_m_resp_data[0];
  assign m1_resp_data       = r_m_resp_data[1];
  assign busy               = (r_state == ST_WAIT);
  assign protocol_err       = r_protocol_err;
  assign dbg_state          = r_state[0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point, so after step()
// the outputs show what the design registered at the edge just passed.
// Build with ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES = 16).

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_request_enable = 1'b0, m1_request_enable = 1'b0;
  logic        m0_req_mode = 1'b0, m1_req_mode = 1'b0;
  logic [31:0] m0_req_addr = '0, m1_req_addr = '0;
  logic [31:0] m0_req_wdata = '0, m1_req_wdata = '0;
  logic [3:0]  m0_req_wstrb = '0, m1_req_wstrb = '0;
  logic        m0_response_enable, m1_response_enable;
  logic [31:0] m0_resp_data, m1_resp_data;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable = 1'b0;
  logic [31:0] resp_data = '0;
  logic        busy, protocol_err, timeout_err, dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int n_req    = 0;
  int n_r0     = 0;
  int n_r1     = 0;

  // Clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_request_enable(m0_request_enable), .m0_req_mode(m0_req_mode),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_response_enable(m0_response_enable), .m0_resp_data(m0_resp_data),
    .m1_request_enable(m1_request_enable), .m1_req_mode(m1_req_mode),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_response_enable(m1_response_enable), .m1_resp_data(m1_resp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy), .protocol_err(protocol_err), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // Pulse counters used to prove "exactly one" / "none" properties.
  always @(posedge clk) begin
    if (request_enable)     n_req++;
    if (m0_response_enable) n_r0++;
    if (m1_response_enable) n_r1++;
  end

  // Driver tasks: set pulse fields, then step() advances one cycle and
  // drops every one-cycle pulse.
  task automatic step();
    @(posedge clk); #1;
    m0_request_enable = 1'b0;
    m1_request_enable = 1'b0;
    response_enable   = 1'b0;
  endtask

  task automatic drive_m0(input logic mode, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    m0_request_enable = 1'b1; m0_req_mode = mode; m0_req_addr = addr; m0_req_wdata = wd; m0_req_wstrb = ws;
  endtask

  task automatic drive_m1(input logic mode, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    m1_request_enable = 1'b1; m1_req_mode = mode; m1_req_addr = addr; m1_req_wdata = wd; m1_req_wstrb = ws;
  endtask

  task automatic mem_resp(input logic [31:0] d);
    response_enable = 1'b1; resp_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    int r0, r1;
    do_reset();
    n_checks++; if (request_enable !== 1'b0) begin n_fails++; $display("FAIL reset_req_en: got %b expected 0", request_enable); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (dbg_state !== 1'b0) begin n_fails++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    n_checks++; if ({m0_response_enable, m1_response_enable} !== 2'b00) begin n_fails++; $display("FAIL reset_resp_en: got %b expected 00", {m0_response_enable, m1_response_enable}); end
    n_checks++; if ({m0_resp_data, m1_resp_data} !== 64'h0) begin n_fails++; $display("FAIL reset_resp_data: got %h expected 0", {m0_resp_data, m1_resp_data}); end
    n_checks++; if ({req_mode, req_addr, req_wdata, req_wstrb} !== 69'h0) begin n_fails++; $display("FAIL reset_req_fields: got %h expected 0", {req_mode, req_addr, req_wdata, req_wstrb}); end
    n_checks++; if ({protocol_err, timeout_err} !== 2'b00) begin n_fails++; $display("FAIL reset_errs: got %b expected 00", {protocol_err, timeout_err}); end
    // Stray memory response in IDLE must not reach either master.
    r0 = n_r0; r1 = n_r1;
    mem_resp(32'hAAAA_5555); step(); step();
    n_checks++; if ((n_r0 - r0) + (n_r1 - r1) !== 0) begin n_fails++; $display("FAIL idle_stray_resp: got %0d pulses expected 0", (n_r0 - r0) + (n_r1 - r1)); end
    n_checks++; if (m0_resp_data !== 32'h0) begin n_fails++; $display("FAIL idle_stray_data: got %h expected 0", m0_resp_data); end
  endtask

  task automatic test_single_read();
    int r1;
    r1 = n_r1;
    drive_m0(1'b0, 32'h8000_0010, 32'h0, 4'hF); step();       // T+1
    n_checks++; if (request_enable !== 1'b1) begin n_fails++; $display("FAIL single_req_en: got %b expected 1", request_enable); end
    n_checks++; if ({req_mode, req_addr, req_wstrb} !== {1'b0, 32'h8000_0010, 4'hF}) begin n_fails++; $display("FAIL single_req_fields: got %h expected %h", {req_mode, req_addr, req_wstrb}, {1'b0, 32'h8000_0010, 4'hF}); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    step();                                                    // T+2
    n_checks++; if (request_enable !== 1'b0) begin n_fails++; $display("FAIL single_req_once: got %b expected 0", request_enable); end
    step(); step(); step();                                    // T+5
    mem_resp(32'h1234_5678); step();                           // T+6
    n_checks++; if (m0_response_enable !== 1'b1) begin n_fails++; $display("FAIL single_resp_en: got %b expected 1", m0_response_enable); end
    n_checks++; if (m0_resp_data !== 32'h1234_5678) begin n_fails++; $display("FAIL single_resp_data: got %h expected 12345678", m0_resp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    step();                                                    // T+7
    n_checks++; if ({m0_response_enable, m0_resp_data} !== {1'b0, 32'h1234_5678}) begin n_fails++; $display("FAIL single_resp_hold: got %h expected 012345678", {m0_response_enable, m0_resp_data}); end
    n_checks++; if (n_r1 - r1 !== 0) begin n_fails++; $display("FAIL single_m1_quiet: got %0d pulses expected 0", n_r1 - r1); end
  endtask

  task automatic test_tie();
    do_reset();
    // After reset rr_last = 1, so m0 wins the first tie.
    drive_m0(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    drive_m1(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'h3); step();
    n_checks++; if ({request_enable, req_addr} !== {1'b1, 32'h0000_1000}) begin n_fails++; $display("FAIL tie1_first: got %h expected 100001000", {request_enable, req_addr}); end
    step(); mem_resp(32'h0000_0111); step();                   // response cycle R, now R+1
    n_checks++; if ({m0_response_enable, request_enable} !== 2'b10) begin n_fails++; $display("FAIL tie1_m0_resp: got %b expected 10", {m0_response_enable, request_enable}); end
    step();                                                    // R+2
    n_checks++; if ({request_enable, req_mode, req_addr, req_wdata, req_wstrb} !== {2'b11, 32'h0000_2000, 32'hCAFE_F00D, 4'h3}) begin n_fails++; $display("FAIL tie1_second: got %h expected %h", {request_enable, req_mode, req_addr, req_wdata, req_wstrb}, {2'b11, 32'h0000_2000, 32'hCAFE_F00D, 4'h3}); end
    step(); mem_resp(32'h0000_0222); step();
    n_checks++; if ({m1_response_enable, m0_response_enable, m1_resp_data} !== {2'b10, 32'h0000_0222}) begin n_fails++; $display("FAIL tie1_m1_resp: got %h expected %h", {m1_response_enable, m0_response_enable, m1_resp_data}, {2'b10, 32'h0000_0222}); end
    // A lone m0 transaction leaves rr_last = 0, so m1 wins the next tie.
    drive_m0(1'b0, 32'h0000_3000, 32'h0, 4'h1); step();
    mem_resp(32'h0000_0333); step(); step();
    drive_m0(1'b0, 32'h0000_4000, 32'h0, 4'h2);
    drive_m1(1'b0, 32'h0000_5000, 32'h0, 4'h4); step();
    n_checks++; if ({request_enable, req_addr} !== {1'b1, 32'h0000_5000}) begin n_fails++; $display("FAIL tie2_first: got %h expected 100005000", {request_enable, req_addr}); end
    mem_resp(32'h0000_0555); step();
    n_checks++; if ({m1_response_enable, m1_resp_data} !== {1'b1, 32'h0000_0555}) begin n_fails++; $display("FAIL tie2_m1_resp: got %h expected 100000555", {m1_response_enable, m1_resp_data}); end
    step();
    n_checks++; if ({request_enable, req_addr, req_wstrb} !== {1'b1, 32'h0000_4000, 4'h2}) begin n_fails++; $display("FAIL tie2_second: got %h expected %h", {request_enable, req_addr, req_wstrb}, {1'b1, 32'h0000_4000, 4'h2}); end
    mem_resp(32'h0000_0444); step(); step();
  endtask

  task automatic test_buffered();
    drive_m0(1'b0, 32'h0001_0000, 32'h0, 4'hF); step();        // T+1
    step();                                                    // T+2
    drive_m1(1'b1, 32'h0002_0040, 32'h5A5A_A5A5, 4'hA); step(); // T+3
    n_checks++; if ({request_enable, busy} !== 2'b01) begin n_fails++; $display("FAIL buf_no_issue_in_wait: got %b expected 01", {request_enable, busy}); end
    mem_resp(32'h0BAD_F00D); step();                           // T+4
    n_checks++; if ({m0_response_enable, request_enable} !== 2'b10) begin n_fails++; $display("FAIL buf_m0_resp: got %b expected 10", {m0_response_enable, request_enable}); end
    step();                                                    // T+5
    n_checks++; if ({request_enable, req_mode, req_addr, req_wdata, req_wstrb} !== {2'b11, 32'h0002_0040, 32'h5A5A_A5A5, 4'hA}) begin n_fails++; $display("FAIL buf_issue: got %h expected %h", {request_enable, req_mode, req_addr, req_wdata, req_wstrb}, {2'b11, 32'h0002_0040, 32'h5A5A_A5A5, 4'hA}); end
    mem_resp(32'h7777_0000); step();
    n_checks++; if ({m1_response_enable, m1_resp_data, protocol_err} !== {1'b1, 32'h7777_0000, 1'b0}) begin n_fails++; $display("FAIL buf_m1_resp: got %h expected %h", {m1_response_enable, m1_resp_data, protocol_err}, {1'b1, 32'h7777_0000, 1'b0}); end
    step();
  endtask

  task automatic test_protocol_err();
    int q0;
    do_reset();
    q0 = n_req;
    drive_m0(1'b0, 32'h0000_00A0, 32'h0, 4'hF); step(); step(); // T+2
    n_checks++; if (protocol_err !== 1'b0) begin n_fails++; $display("FAIL perr_before: got %b expected 0", protocol_err); end
    drive_m0(1'b1, 32'h0000_00B0, 32'h1, 4'h1); step();         // T+3
    n_checks++; if (protocol_err !== 1'b1) begin n_fails++; $display("FAIL perr_set: got %b expected 1", protocol_err); end
    mem_resp(32'h0000_0001); step(); step(); step(); step();
    n_checks++; if (n_req - q0 !== 1) begin n_fails++; $display("FAIL perr_one_req: got %0d expected 1", n_req - q0); end
    n_checks++; if ({busy, req_addr, protocol_err} !== {1'b0, 32'h0000_00A0, 1'b1}) begin n_fails++; $display("FAIL perr_end: got %h expected %h", {busy, req_addr, protocol_err}, {1'b0, 32'h0000_00A0, 1'b1}); end
  endtask

  task automatic test_reset_mid_wait();
    int r0, r1;
    drive_m0(1'b0, 32'h0000_0C00, 32'h0, 4'hF); step();        // WAIT cycle 1
    step(); step();                                            // WAIT cycle 3
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if ({busy, dbg_state} !== 2'b00) begin n_fails++; $display("FAIL rstwait_idle: got %b expected 00", {busy, dbg_state}); end
    r0 = n_r0; r1 = n_r1;
    mem_resp(32'hFFFF_0000); step(); step();
    n_checks++; if ((n_r0 - r0) + (n_r1 - r1) !== 0) begin n_fails++; $display("FAIL rstwait_no_resp: got %0d pulses expected 0", (n_r0 - r0) + (n_r1 - r1)); end
    n_checks++; if ({busy, request_enable, m0_resp_data} !== {2'b00, 32'h0}) begin n_fails++; $display("FAIL rstwait_quiet: got %h expected 0", {busy, request_enable, m0_resp_data}); end
    drive_m1(1'b0, 32'h0000_0D00, 32'h0, 4'h6); step();
    n_checks++; if ({request_enable, req_addr, req_wstrb} !== {1'b1, 32'h0000_0D00, 4'h6}) begin n_fails++; $display("FAIL rstwait_m1_req: got %h expected %h", {request_enable, req_addr, req_wstrb}, {1'b1, 32'h0000_0D00, 4'h6}); end
    mem_resp(32'h0000_0DDD); step();
    n_checks++; if ({m1_response_enable, m1_resp_data} !== {1'b1, 32'h0000_0DDD}) begin n_fails++; $display("FAIL rstwait_m1_resp: got %h expected 100000ddd", {m1_response_enable, m1_resp_data}); end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    drive_m0(1'b0, 32'h0000_0E00, 32'h0, 4'hF); step();        // WAIT cycle 1
`ifdef ARB_TIMEOUT_EN
    repeat (15) step();                                        // WAIT cycle 16
    n_checks++; if ({busy, m0_response_enable, timeout_err} !== 3'b100) begin n_fails++; $display("FAIL to_last_wait: got %b expected 100", {busy, m0_response_enable, timeout_err}); end
    step();
    n_checks++; if ({m0_response_enable, m0_resp_data} !== {1'b1, 32'hDEAD_BEEF}) begin n_fails++; $display("FAIL to_resp: got %h expected 1deadbeef", {m0_response_enable, m0_resp_data}); end
    n_checks++; if ({timeout_err, busy} !== 2'b10) begin n_fails++; $display("FAIL to_flags: got %b expected 10", {timeout_err, busy}); end
`else
    repeat (40) step();
    n_checks++; if ({busy, m0_response_enable, timeout_err} !== 3'b100) begin n_fails++; $display("FAIL no_to_wait: got %b expected 100", {busy, m0_response_enable, timeout_err}); end
    mem_resp(32'h0000_0EEE); step();
    n_checks++; if ({m0_response_enable, m0_resp_data, timeout_err} !== {1'b1, 32'h0000_0EEE, 1'b0}) begin n_fails++; $display("FAIL no_to_resp: got %h expected %h", {m0_response_enable, m0_resp_data, timeout_err}, {1'b1, 32'h0000_0EEE, 1'b0}); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_buffered();
    test_protocol_err();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
